// File: rtl/and_share_arbiter.sv
// and_share_arbiter: round-robin arbiter sharing one WIDTH-bit bitwise-AND
// unit among NREQ requesters. The AND result and the requester index are
// registered and held under valid/ready backpressure.
// Optional feature macro: AND_ARB_STATS_EN adds a saturating 16-bit grant
// counter on output port txn_cnt.
module and_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   op_a,
  input  logic [NREQ*WIDTH-1:0]   op_b,
  output logic [NREQ-1:0]         gnt,
  output logic                    res_valid,
  output logic [WIDTH-1:0]        res_data,
  output logic [IDW-1:0]          res_id,
  input  logic                    res_ready
`ifdef AND_ARB_STATS_EN
  ,output logic [15:0]            txn_cnt
`endif
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDW-1:0]   r_rr_ptr;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;

  logic [IDW-1:0]   w_cand;
  logic [IDW-1:0]   w_sel;
  logic             w_found;
  logic             w_can_accept;
  logic             w_grant;
  logic [WIDTH-1:0] w_and;

  // Round-robin search: first pending requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_cand = IDW'((32'(r_rr_ptr) + k) % NREQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // A grant needs a free or draining output register and no reset this cycle.
  always_comb begin
    w_can_accept = (r_state == ST_EMPTY) | res_ready;
    w_grant      = w_found & w_can_accept & ~rst;
    w_and        = op_a[w_sel*WIDTH +: WIDTH] & op_b[w_sel*WIDTH +: WIDTH];
  end

  // One-hot grant, driven combinationally in the request cycle.
  always_comb begin
    gnt = '0;
    if (w_grant) begin
      gnt[w_sel] = 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: fill on grant, empty on drain without a new grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_grant) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (res_ready && !w_grant) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // FSM outputs: valid is simply the FULL state.
  always_comb begin
    res_valid = 1'b0;
    if (r_state == ST_FULL) begin
      res_valid = 1'b1;
    end
  end

  // Result register and round-robin pointer; both advance only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_data <= '0;
      r_res_id   <= '0;
      r_rr_ptr   <= '0;
    end else if (w_grant) begin
      r_res_data <= w_and;
      r_res_id   <= w_sel;
      r_rr_ptr   <= (32'(w_sel) == NREQ - 1) ? '0 : w_sel + IDW'(1);
    end
  end

  assign res_data = r_res_data;
  assign res_id   = r_res_id;

`ifdef AND_ARB_STATS_EN
  logic [15:0] r_txn_cnt;

  // Grant counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txn_cnt <= '0;
    end else if (w_grant && (r_txn_cnt != 16'hFFFF)) begin
      r_txn_cnt <= r_txn_cnt + 16'd1;
    end
  end

  assign txn_cnt = r_txn_cnt;
`endif

endmodule

// File: tb/tb_and_share_arbiter.sv
// Bench for and_share_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model of the arbiter.
module tb_and_share_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [3:0]  gnt;
  logic        res_valid;
  logic [3:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready;
`ifdef AND_ARB_STATS_EN
  logic [15:0] txn_cnt;
`endif

  and_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready)
`ifdef AND_ARB_STATS_EN
    ,.txn_cnt  (txn_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: what the output register holds and whose turn it is.
  bit       m_known = 0;
  bit       m_valid = 0;
  int       m_data  = 0;
  int       m_id    = 0;
  int       m_ptr   = 0;
  int       m_cnt   = 0;
  int       exp_gnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Winner is the pending requester with the smallest forward distance from m_ptr.
  function automatic int pick(input logic [3:0] r, input int ptr);
    int best = -1;
    int best_d = 99;
    for (int i = 0; i < 4; i++) begin
      int d = (i - ptr + 4) % 4;
      if (r[i] && d < best_d) begin
        best = i;
        best_d = d;
      end
    end
    return best;
  endfunction

  // Apply one cycle of inputs, compare against the model, then advance the model.
  task automatic step(input logic [3:0] r, input logic [15:0] a, input logic [15:0] b,
                      input logic rd, input logic rs);
    int w;
    @(negedge clk);
    req = r; op_a = a; op_b = b; res_ready = rd; rst = rs;
    #2;
    w = pick(r, m_ptr);
    if (rs || (m_valid && !rd) || w < 0) exp_gnt = 0;
    else exp_gnt = 1 << w;
    chk("gnt", int'(gnt), exp_gnt);
    if (m_known) begin
      chk("res_valid", int'(res_valid), int'(m_valid));
      chk("res_data", int'(res_data), m_data);
      chk("res_id", int'(res_id), m_id);
`ifdef AND_ARB_STATS_EN
      chk("txn_cnt", int'(txn_cnt), m_cnt);
`endif
    end
    if (rs) begin
      m_known = 1; m_valid = 0; m_data = 0; m_id = 0; m_ptr = 0; m_cnt = 0;
    end else if (exp_gnt != 0) begin
      m_data  = int'((a >> (w * 4)) & (b >> (w * 4)) & 16'hF);
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % 4;
      if (m_cnt < 16'hFFFF) m_cnt++;
    end else if (m_valid && rd) begin
      m_valid = 0;
    end
  endtask

  initial begin
    logic [3:0] grant_order [8];
    req = '0; op_a = '0; op_b = '0; res_ready = 1'b0; rst = 1'b1;

    // Reset held two cycles with all requests asserted.
    step(4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    chk("lit_rst_gnt0", int'(gnt), 0);
    step(4'hF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    chk("lit_rst_gnt1", int'(gnt), 0);

    // Single request from requester 2: 0xB & 0x6 = 0x2.
    step(4'b0100, 16'h0B00, 16'h0600, 1'b1, 1'b0);
    chk("lit_rst_valid", int'(res_valid), 0);
    chk("lit_single_gnt", int'(gnt), 4'b0100);
    step(4'b0000, 16'h0000, 16'h0000, 1'b1, 1'b0);
    chk("lit_single_valid", int'(res_valid), 1);
    chk("lit_single_data", int'(res_data), 4'h2);
    chk("lit_single_id", int'(res_id), 2);

    // Fairness from a fresh pointer: 0,1,2,3,0,1,2,3.
    step(4'h0, 16'h0, 16'h0, 1'b1, 1'b1);
    for (int c = 0; c < 8; c++) begin
      step(4'hF, 16'h1234, 16'hFFFF, 1'b1, 1'b0);
      grant_order[c] = gnt;
    end
    for (int c = 0; c < 8; c++) chk("lit_fair_order", int'(grant_order[c]), 1 << (c % 4));

    // Backpressure: full with ready low holds the result and blocks grants.
    for (int c = 0; c < 5; c++) begin
      step(4'b0011, 16'h00A5, 16'h00FF, 1'b0, 1'b0);
      chk("lit_bp_gnt", int'(gnt), 0);
      chk("lit_bp_id", int'(res_id), 3);
    end
    step(4'b0011, 16'h00A5, 16'h00FF, 1'b1, 1'b0);
    chk("lit_bp_release_gnt", int'(gnt), 4'b0001);
    step(4'b0000, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("lit_bp_release_valid", int'(res_valid), 1);
    chk("lit_bp_release_data", int'(res_data), 4'h5);

    // Wrap and skip: pointer at 3, only requester 1 pending, then 0 and 3.
    step(4'b0100, 16'h0F00, 16'h0F00, 1'b1, 1'b0);
    step(4'b0010, 16'h00C0, 16'h00F0, 1'b1, 1'b0);
    chk("lit_wrap_gnt", int'(gnt), 4'b0010);
    step(4'b1001, 16'hF00F, 16'h700E, 1'b1, 1'b0);
    chk("lit_skip_gnt", int'(gnt), 4'b1000);
    step(4'b0000, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("lit_skip_data", int'(res_data), 4'h7);

    // Mid-operation reset drops the held result and rewinds the pointer.
    step(4'b0000, 16'h0, 16'h0, 1'b0, 1'b1);
    step(4'hF, 16'hFFFF, 16'h1111, 1'b1, 1'b0);
    chk("lit_midrst_valid", int'(res_valid), 0);
    chk("lit_midrst_gnt", int'(gnt), 4'b0001);

    // Random traffic with occasional reset.
    for (int c = 0; c < 3000; c++) begin
      step(4'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
